// File: rtl/bw_io_cmos2_pad_bank.sv
// CMOS2 bidirectional pad bank: registered output path, break-before-make drive-code update,
// synchronised/debounced receive path. Optional boundary-scan mux under BW_IO_PAD_BSR_EN.
module bw_io_cmos2_pad_bank #(
    parameter int unsigned     NCH      = 8,
    parameter int unsigned     CBW      = 8,
    parameter logic [CBW-1:0]  CB_RST   = 8'h0F,
    parameter int unsigned     FILT_W   = 4,
    parameter int unsigned     TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              por_l,
    input  logic [NCH-1:0]    core_data,
    input  logic [NCH-1:0]    core_oe,
    input  logic [CBW-1:0]    cfg_cbu,
    input  logic [CBW-1:0]    cfg_cbd,
    input  logic              cfg_vld,
    output logic              cfg_rdy,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [NCH-1:0]    rcvr_data,
    input  logic [NCH-1:0]    sticky_clr,
`ifdef BW_IO_PAD_BSR_EN
    input  logic              bsr_mode,
    input  logic [NCH-1:0]    bsr_data,
    input  logic [NCH-1:0]    bsr_oe,
    output logic [NCH-1:0]    bsr_cap,
`endif
    output logic [NCH-1:0]    pad_data,
    output logic [NCH-1:0]    pad_oe,
    output logic [CBW-1:0]    pad_cbu,
    output logic [CBW-1:0]    pad_cbd,
    output logic [NCH-1:0]    to_core,
    output logic [NCH-1:0]    edge_evt,
    output logic [NCH-1:0]    edge_sticky
);

    localparam int unsigned TW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {StIdle, StDrain, StApply} state_e;

    state_e            state_q;
    logic [TW-1:0]     turn_q;
    logic [CBW-1:0]    cbu_q, cbd_q, pend_cbu_q, pend_cbd_q;
    logic              rdy_q;
    logic [NCH-1:0]    data_q, oe_q;
    logic [NCH-1:0]    data_src, oe_src;
    logic              freeze;
    logic [NCH-1:0]    sync_q1, sync_q2, core_q, evt_q, sticky_q;
    logic [FILT_W-1:0] cnt_q [NCH];

`ifdef BW_IO_PAD_BSR_EN
    assign data_src = bsr_mode ? bsr_data : core_data;
    assign oe_src   = bsr_mode ? bsr_oe : core_oe;
    assign freeze   = bsr_mode;
    assign bsr_cap  = sync_q2;
`else
    assign data_src = core_data;
    assign oe_src   = core_oe;
    assign freeze   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            data_q <= '0;
            oe_q   <= '0;
        end else begin
            data_q <= data_src;
            oe_q   <= oe_src;
        end
    end

    // New codes land while every driver is tristated; enables return once DRAIN is left.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q    <= StIdle;
            turn_q     <= '0;
            cbu_q      <= CB_RST;
            cbd_q      <= CB_RST;
            pend_cbu_q <= CB_RST;
            pend_cbd_q <= CB_RST;
            rdy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_vld) begin
                        pend_cbu_q <= cfg_cbu;
                        pend_cbd_q <= cfg_cbd;
                        turn_q     <= TW'(TURN_CYC);
                        rdy_q      <= 1'b0;
                        state_q    <= StDrain;
                    end
                end
                StDrain: begin
                    if (turn_q == TW'(1)) begin
                        cbu_q   <= pend_cbu_q;
                        cbd_q   <= pend_cbd_q;
                        state_q <= StApply;
                    end else begin
                        turn_q <= turn_q - TW'(1);
                    end
                end
                StApply: begin
                    rdy_q   <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            core_q   <= '0;
            evt_q    <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            sync_q1 <= rcvr_data;
            sync_q2 <= sync_q1;
            if (freeze) begin
                evt_q <= '0;
            end else begin
                sticky_q <= (sticky_q & ~sticky_clr) | evt_q;
                for (int i = 0; i < NCH; i++) begin
                    evt_q[i] <= 1'b0;
                    if (sync_q2[i] == core_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] >= filt_len) begin
                        core_q[i] <= sync_q2[i];
                        cnt_q[i]  <= '0;
                        evt_q[i]  <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + FILT_W'(1);
                    end
                end
            end
        end
    end

    assign cfg_rdy     = rdy_q;
    assign pad_data    = data_q;
    assign pad_oe      = oe_q & {NCH{por_l}} & ~{NCH{state_q == StDrain}};
    assign pad_cbu     = cbu_q;
    assign pad_cbd     = cbd_q;
    assign to_core     = core_q;
    assign edge_evt    = evt_q;
    assign edge_sticky = sticky_q;

endmodule

// File: tb/tb_bw_io_cmos2_pad_bank.sv
// Self-checking bench for bw_io_cmos2_pad_bank: directed scenarios plus randomized traffic
// against a sample-history reference model.
module tb_bw_io_cmos2_pad_bank;

    localparam int unsigned    NCH      = 8;
    localparam int unsigned    CBW      = 8;
    localparam logic [CBW-1:0] CB_RST   = 8'h0F;
    localparam int unsigned    FILT_W   = 4;
    localparam int unsigned    TURN_CYC = 2;

    logic              clk;
    logic              rst_l, por_l, cfg_vld, cfg_rdy;
    logic [NCH-1:0]    core_data, core_oe, rcvr_data, sticky_clr;
    logic [CBW-1:0]    cfg_cbu, cfg_cbd, pad_cbu, pad_cbd;
    logic [FILT_W-1:0] filt_len;
    logic [NCH-1:0]    pad_data, pad_oe, to_core, edge_evt, edge_sticky;
`ifdef BW_IO_PAD_BSR_EN
    logic              bsr_mode;
    logic [NCH-1:0]    bsr_data, bsr_oe, bsr_cap;
`endif

    bw_io_cmos2_pad_bank #(
        .NCH(NCH), .CBW(CBW), .CB_RST(CB_RST), .FILT_W(FILT_W), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk(clk), .rst_l(rst_l), .por_l(por_l),
        .core_data(core_data), .core_oe(core_oe),
        .cfg_cbu(cfg_cbu), .cfg_cbd(cfg_cbd), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .filt_len(filt_len), .rcvr_data(rcvr_data), .sticky_clr(sticky_clr),
`ifdef BW_IO_PAD_BSR_EN
        .bsr_mode(bsr_mode), .bsr_data(bsr_data), .bsr_oe(bsr_oe), .bsr_cap(bsr_cap),
`endif
        .pad_data(pad_data), .pad_oe(pad_oe), .pad_cbu(pad_cbu), .pad_cbd(pad_cbd),
        .to_core(to_core), .edge_evt(edge_evt), .edge_sticky(edge_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: drive sequencing as a busy countdown, receive filter as a history of
    // synchronised samples (a value is accepted once filt_len+1 consecutive samples disagree).
    logic [NCH-1:0] m_data = '0, m_oe = '0, m_s1 = '0, m_s2 = '0;
    logic [NCH-1:0] m_core = '0, m_evt = '0, m_sticky = '0;
    logic [CBW-1:0] m_cbu = CB_RST, m_cbd = CB_RST, m_pu = CB_RST, m_pd = CB_RST;
    int             m_busy = 0;
    logic [NCH-1:0] hist [$];

    task automatic model_step();
        logic [NCH-1:0] sample;
        bit ok, frozen;
        if (!rst_l) begin
            m_data = '0; m_oe = '0; m_s1 = '0; m_s2 = '0;
            m_core = '0; m_evt = '0; m_sticky = '0;
            m_cbu = CB_RST; m_cbd = CB_RST; m_busy = 0;
            hist.delete();
            return;
        end
        frozen = 1'b0;
        m_data = core_data;
        m_oe   = core_oe;
`ifdef BW_IO_PAD_BSR_EN
        if (bsr_mode) begin
            m_data = bsr_data;
            m_oe   = bsr_oe;
            frozen = 1'b1;
        end
`endif
        if (m_busy == 0) begin
            if (cfg_vld) begin
                m_busy = TURN_CYC + 1;
                m_pu = cfg_cbu;
                m_pd = cfg_cbd;
            end
        end else begin
            m_busy--;
            if (m_busy == 1) begin
                m_cbu = m_pu;
                m_cbd = m_pd;
            end
        end
        sample = m_s2;
        m_s2 = m_s1;
        m_s1 = rcvr_data;
        if (frozen) begin
            m_evt = '0;
        end else begin
            m_sticky = (m_sticky & ~sticky_clr) | m_evt;
            hist.push_back(sample);
            if (hist.size() > 20) void'(hist.pop_front());
            m_evt = '0;
            for (int i = 0; i < NCH; i++) begin
                ok = (hist.size() >= int'(filt_len) + 1);
                for (int k = 0; ok && k <= int'(filt_len); k++)
                    if (hist[hist.size() - 1 - k][i] == m_core[i]) ok = 1'b0;
                if (ok) begin
                    m_core[i] = ~m_core[i];
                    m_evt[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] exp_oe;
        exp_oe = m_oe & {NCH{por_l}} & ((m_busy > 1) ? {NCH{1'b0}} : {NCH{1'b1}});
        chk("pad_data", 32'(pad_data), 32'(m_data));
        chk("pad_oe", 32'(pad_oe), 32'(exp_oe));
        chk("pad_cbu", 32'(pad_cbu), 32'(m_cbu));
        chk("pad_cbd", 32'(pad_cbd), 32'(m_cbd));
        chk("cfg_rdy", 32'(cfg_rdy), 32'(m_busy == 0));
        chk("to_core", 32'(to_core), 32'(m_core));
        chk("edge_evt", 32'(edge_evt), 32'(m_evt));
        chk("edge_sticky", 32'(edge_sticky), 32'(m_sticky));
`ifdef BW_IO_PAD_BSR_EN
        chk("bsr_cap", 32'(bsr_cap), 32'(m_s2));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [NCH-1:0] held;
        rst_l = 1'b0; por_l = 1'b1; core_data = '0; core_oe = '0;
        cfg_cbu = '0; cfg_cbd = '0; cfg_vld = 1'b0; filt_len = '0;
        rcvr_data = '0; sticky_clr = '0;
`ifdef BW_IO_PAD_BSR_EN
        bsr_mode = 1'b0; bsr_data = '0; bsr_oe = '0;
`endif
        @(negedge clk);
        step(); step();
        chk("rst_pad_oe", 32'(pad_oe), 32'h00);
        chk("rst_cbu", 32'(pad_cbu), 32'h0F);
        chk("rst_cbd", 32'(pad_cbd), 32'h0F);
        chk("rst_cfg_rdy", 32'(cfg_rdy), 32'h1);
        chk("rst_to_core", 32'(to_core), 32'h00);

        rst_l = 1'b1; core_oe = 8'hFF; core_data = 8'hA5;
        step();
        chk("out_oe", 32'(pad_oe), 32'hFF);
        chk("out_data", 32'(pad_data), 32'hA5);

        cfg_cbu = 8'h3F; cfg_cbd = 8'h1F; cfg_vld = 1'b1;
        step();
        chk("drain1_rdy", 32'(cfg_rdy), 32'h0);
        chk("drain1_oe", 32'(pad_oe), 32'h00);
        cfg_cbu = 8'h77; cfg_cbd = 8'h77;
        step();
        chk("drain2_oe", 32'(pad_oe), 32'h00);
        chk("drain2_cbu", 32'(pad_cbu), 32'h0F);
        cfg_vld = 1'b0;
        step();
        chk("apply_cbu", 32'(pad_cbu), 32'h3F);
        chk("apply_cbd", 32'(pad_cbd), 32'h1F);
        chk("apply_oe", 32'(pad_oe), 32'hFF);
        chk("apply_rdy", 32'(cfg_rdy), 32'h0);
        step();
        chk("idle_rdy", 32'(cfg_rdy), 32'h1);
        chk("idle_cbu", 32'(pad_cbu), 32'h3F);

        filt_len = 4'd4; rcvr_data[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 7) chk("filt_early", 32'(to_core[0]), 32'h0);
            if (k == 7) begin
                chk("filt_edge7", 32'(to_core[0]), 32'h1);
                chk("filt_evt7", 32'(edge_evt[0]), 32'h1);
            end
            if (k == 8) begin
                chk("filt_evt8", 32'(edge_evt[0]), 32'h0);
                chk("filt_sticky", 32'(edge_sticky[0]), 32'h1);
            end
        end

        rcvr_data[1] = 1'b1;
        step(); step(); step();
        rcvr_data[1] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("glitch_core", 32'(to_core[1]), 32'h0);
        chk("glitch_sticky", 32'(edge_sticky[1]), 32'h0);

        rcvr_data[0] = 1'b0; filt_len = 4'd0;
        step(); step(); step();
        chk("fall_evt", 32'(edge_evt[0]), 32'h1);
        sticky_clr[0] = 1'b1;
        step();
        chk("set_wins", 32'(edge_sticky[0]), 32'h1);
        step();
        chk("clr_alone", 32'(edge_sticky[0]), 32'h0);
        sticky_clr = '0;

        por_l = 1'b0;
        #1;
        chk("por_imm_oe", 32'(pad_oe), 32'h00);
        step();
        chk("por_cbu", 32'(pad_cbu), 32'h3F);
        por_l = 1'b1;

        cfg_cbu = 8'hAA; cfg_cbd = 8'h55; cfg_vld = 1'b1;
        step();
        cfg_vld = 1'b0; rst_l = 1'b0;
        step();
        chk("midrst_rdy", 32'(cfg_rdy), 32'h1);
        chk("midrst_cbu", 32'(pad_cbu), 32'h0F);
        rst_l = 1'b1;
        step(); step(); step();
        chk("postrst_cbd", 32'(pad_cbd), 32'h0F);

        for (int n = 0; n < 2000; n++) begin
            rst_l      = ($urandom_range(0, 199) != 0);
            por_l      = ($urandom_range(0, 19) != 0);
            core_data  = NCH'($urandom);
            core_oe    = NCH'($urandom);
            cfg_vld    = ($urandom_range(0, 5) == 0);
            cfg_cbu    = CBW'($urandom);
            cfg_cbd    = CBW'($urandom);
            sticky_clr = NCH'($urandom & $urandom & $urandom);
            rcvr_data  = rcvr_data ^ NCH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 29) == 0) filt_len = FILT_W'($urandom_range(0, 5));
            step();
        end

`ifdef BW_IO_PAD_BSR_EN
        rst_l = 1'b1; por_l = 1'b1; cfg_vld = 1'b0;
        for (int k = 0; k < 5; k++) step();
        bsr_mode = 1'b1; bsr_data = 8'h5A; bsr_oe = 8'hFF; filt_len = 4'd0;
        step();
        chk("bsr_data", 32'(pad_data), 32'h5A);
        held = to_core;
        rcvr_data = ~rcvr_data;
        step(); step();
        chk("bsr_cap", 32'(bsr_cap), 32'(rcvr_data));
        step(); step();
        chk("bsr_hold", 32'(to_core), 32'(held));
        bsr_mode = 1'b0;
        for (int k = 0; k < 6; k++) step();
`else
        held = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bw_io_cmos2_pad_bank.md
Name: bw_io_cmos2_pad_bank

Overview:
Parametrised bank controller for NCH CMOS2 bidirectional pads, the successor to the single-channel CMOS2 pad wrapper. Registers core data/output-enable per channel and owns a shared, runtime-programmable drive-strength code that is updated with a break-before-make sequence. Synchronises and debounces receiver outputs and reports filtered edges. Sits between core logic and the per-pad hstl driver and schmitt receiver cells.

Parameters:
NCH, 8, number of pad channels
CBW, 8, drive code width (cbu/cbd)
CB_RST, 8'h0F, drive code loaded on reset (both cbu and cbd)
FILT_W, 4, debounce counter / threshold width
TURN_CYC, 2, tristate cycles before a new drive code is applied (legal range >= 1)

Ports:
clk  in  1  bank clock
rst_l  in  1  synchronous reset, active-low
por_l  in  1  power-on reset; low forces all pad_oe to 0
core_data  in  NCH  output data from core
core_oe  in  NCH  output enable from core
cfg_cbu  in  CBW  requested pull-up drive code
cfg_cbd  in  CBW  requested pull-down drive code
cfg_vld  in  1  drive code request valid
cfg_rdy  out  1  drive code request accepted when high with cfg_vld
filt_len  in  FILT_W  debounce threshold, in cycles
rcvr_data  in  NCH  asynchronous schmitt receiver outputs
sticky_clr  in  NCH  per-channel clear of edge_sticky
pad_data  out  NCH  data to pad drivers
pad_oe  out  NCH  enable to pad drivers
pad_cbu  out  CBW  drive code to all drivers
pad_cbd  out  CBW  drive code to all drivers
to_core  out  NCH  filtered receive data
edge_evt  out  NCH  one-cycle pulse on to_core change
edge_sticky  out  NCH  latched edge_evt

Behaviour:
- Reset, rst_l=0 at posedge: pad_data=0, pad_oe=0, pad_cbu=pad_cbd=CB_RST, cfg_rdy=1, FSM=IDLE, sync flops, counters, to_core, edge_evt and edge_sticky all 0.
- Output path: pad_data/pad_oe register core_data/core_oe with 1-cycle latency.
- pad_oe = registered oe AND por_l AND not(FSM==DRAIN). The por_l gating is combinational. por_l does not reset any other state.
- Drive FSM IDLE/DRAIN/APPLY:
  - IDLE: cfg_rdy=1. On cfg_vld, latch codes, load the turn counter with TURN_CYC, and go to DRAIN.
  - DRAIN: cfg_rdy=0. All pad_oe are 0. The counter decrements each cycle; at 1, go to APPLY.
  - APPLY: cfg_rdy=0. pad_cbu/pad_cbd take the latched codes at this edge. Return to IDLE next cycle; pad_oe resumes.
  - Any cfg_vld outside IDLE is ignored. A request equal to the current code still runs the full sequence.
  - rst_l low mid-sequence returns the FSM to IDLE with CB_RST codes.
- Input path, per channel:
  - Two-flop synchroniser (sync_q2).
  - Counter cnt: if sync_q2 == to_core, cnt=0. Otherwise, if cnt >= filt_len, to_core<=sync_q2, cnt=0, and edge_evt=1 next cycle. Otherwise cnt++.
  - Latency from a stable rcvr change to the to_core update is 3+filt_len edges. filt_len=0 gives 3 edges.
  - A glitch shorter than filt_len+1 sync'd cycles is rejected.
  - Lowering filt_len mid-count takes effect immediately because the compare is >=.
  - cnt never exceeds 2^FILT_W-1.
- A pad held high through reset produces to_core rise plus edge_evt after the filter delay. This is intended.
- edge_sticky: set by edge_evt, cleared by sticky_clr. If both occur in the same cycle, set wins.

Optional Feature:
BW_IO_PAD_BSR_EN: adds ports bsr_mode (in 1), bsr_data (in NCH), bsr_oe (in NCH), bsr_cap (out NCH).
- With bsr_mode=1: pad_data/pad_oe register bsr_data/bsr_oe instead of core inputs, still gated by por_l and DRAIN. bsr_cap=sync_q2, unfiltered. to_core, cnt and sticky are frozen.
- bsr_mode=0 behaves as without the macro.
- Without the macro, the ports are absent and no BSR logic exists.

Test Plan:
- Reset with rcvr_data=0 -> pad_oe=0, pad_cbu=pad_cbd=8'h0F, cfg_rdy=1, to_core=0. core_oe=8'hFF, core_data=8'hA5 -> pad_oe=8'hFF, pad_data=8'hA5 one cycle later.
- cfg_vld with cbu=8'h3F, cbd=8'h1F, TURN_CYC=2 -> cfg_rdy low, pad_oe=0 for 2 cycles, codes update in APPLY, pad_oe restored next cycle. A second cfg_vld during DRAIN is ignored.
- filt_len=4, rcvr_data[0] rises and stays -> to_core[0]=1 at edge 7, edge_evt[0] pulses one cycle, edge_sticky[0]=1. A 3-cycle pulse on ch1 -> no change.
- sticky_clr[0] asserted in the same cycle as a new edge_evt[0] -> edge_sticky[0] stays 1. A clear alone -> 0.
- por_l=0 with core_oe=8'hFF -> pad_oe=0 immediately, codes/to_core unaffected. rst_l=0 during DRAIN -> IDLE, codes 8'h0F.
- BW_IO_PAD_BSR_EN: bsr_mode=1, bsr_data=8'h5A, bsr_oe=8'hFF -> pad_data=8'h5A. rcvr toggles -> bsr_cap follows after 2 edges, to_core held.
